// File: rtl/sd_mac_pkg.sv
// Shared definitions for the MAC datapath: default widths and accumulate-stage FSM states.
package sd_mac_pkg;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/sd_sat_add.sv
// Combinational unsigned saturating adder: a + zero-extended b, clamped to all-ones on carry-out.
module sd_sat_add #(
  parameter int A_W = 16,
  parameter int B_W = 8
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [A_W-1:0] sum_o,
  output logic           sat_o
);
  logic [A_W:0] raw_sum;

  assign raw_sum = {1'b0, a_i} + {{(A_W+1-B_W){1'b0}}, b_i};
  assign sat_o   = raw_sum[A_W];
  assign sum_o   = sat_o ? '1 : raw_sum[A_W-1:0];
endmodule

// File: rtl/sd_mac_accumulate.sv
// Accumulate stage of the MAC: sums a run of products with saturation and hands the
// result downstream over valid/ready, together with the term count and overflow flag.
module sd_mac_accumulate #(
  parameter int PROD_W = sd_mac_pkg::PROD_W,
  parameter int ACC_W  = sd_mac_pkg::ACC_W,
  parameter int CNT_W  = sd_mac_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);
  import sd_mac_pkg::*;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              rdy_q;
  logic              accept;
  logic              result_taken;
  logic [ACC_W-1:0]  add_sum;
  logic              add_sat;

  assign accept       = in_valid && rdy_q;
  assign result_taken = (state_q == ST_DONE) && out_ready;

  sd_sat_add #(
    .A_W (ACC_W),
    .B_W (PROD_W)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (prod),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  // in_ready is registered so it stays low through reset and depends on state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_DONE);
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = in_last ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (accept && in_last) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == ST_IDLE && accept) begin
      acc_d = {{(ACC_W-PROD_W){1'b0}}, prod};
      cnt_d = CNT_W'(1);
      ovf_d = 1'b0;
    end else if (state_q == ST_ACCUM && accept) begin
      acc_d = add_sum;
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      ovf_d = ovf_q | add_sat;
    end else if (result_taken) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    in_ready  = rdy_q;
    out_valid = (state_q == ST_DONE);
    acc_out   = acc_q;
    term_cnt  = cnt_q;
    ovf       = ovf_q;
  end
endmodule

// File: tb/tb_sd_mac_accumulate.sv
// Randomized and directed bench for sd_mac_accumulate, checked against a plain-arithmetic run model.
module tb_sd_mac_accumulate;
  localparam longint ACC_MAX = 65535;
  localparam int     CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  prod = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [15:0] acc_out;
  logic [7:0]  term_cnt;
  logic        ovf;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int prod_q[$];
  int gap_q[$];

  sd_mac_accumulate dut (
    .clk       (clk),
    .rst       (rst),
    .prod      (prod),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .term_cnt  (term_cnt),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    prod     = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic send(input int p, input bit last);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    prod     = 8'(p);
    in_last  = last;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    prod     = 8'($urandom);
  endtask

  // Plays prod_q (with idle gaps from gap_q) as one run, then checks and consumes the result.
  task automatic do_run(input int rdy_delay);
    longint total;
    int     n;
    int     exp_acc, exp_cnt, exp_ovf;
    total = 0;
    n     = prod_q.size();
    for (int i = 0; i < n; i++) begin
      repeat (gap_q[i]) idle_cycle();
      send(prod_q[i], i == n - 1);
      total += prod_q[i];
      if (i < n - 1) chk("ov_mid", 32'(out_valid), 32'd0);
    end
    exp_acc = int'((total > ACC_MAX) ? ACC_MAX : total);
    exp_ovf = (total > ACC_MAX) ? 1 : 0;
    exp_cnt = (n > CNT_MAX) ? CNT_MAX : n;
    $display("[TB] run terms=%0d sum=%0d exp_acc=%0d got_acc=%0d cnt=%0d ovf=%0d",
             n, total, exp_acc, acc_out, term_cnt, ovf);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("acc_out", 32'(acc_out), 32'(exp_acc));
    chk("term_cnt", 32'(term_cnt), 32'(exp_cnt));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("rdy_done", 32'(in_ready), 32'd0);
    for (int d = 0; d < rdy_delay; d++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_acc", 32'(acc_out), 32'(exp_acc));
      chk("hold_cnt", 32'(term_cnt), 32'(exp_cnt));
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_after_hs", 32'(out_valid), 32'd0);
    chk("rdy_after_hs", 32'(in_ready), 32'd1);
    chk("acc_clr", 32'(acc_out), 32'd0);
    chk("cnt_clr", 32'(term_cnt), 32'd0);
    chk("ovf_clr", 32'(ovf), 32'd0);
    prod_q.delete();
    gap_q.delete();
  endtask

  task automatic push(input int p, input int g);
    prod_q.push_back(p);
    gap_q.push_back(g);
  endtask

  task automatic pulse_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_cnt", 32'(term_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #4;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int len;
    // Power-on reset, released mid-cycle
    #2;
    chk("por_valid", 32'(out_valid), 32'd0);
    chk("por_rdy", 32'(in_ready), 32'd0);
    chk("por_acc", 32'(acc_out), 32'd0);
    #15;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("por_rdy_rel", 32'(in_ready), 32'd1);

    push(15, 0); push(63, 0); push(225, 0);
    do_run(0);

    push(42, 0);
    do_run(5);

    push(10, 0); push(20, 2); push(30, 1);
    do_run(1);

    for (int i = 0; i < 292; i++) push(225, 0);
    do_run(0);
    push(1, 0);
    do_run(0);

    // Reset mid-run after 2 of 4 terms
    send(7, 0);
    send(9, 0);
    pulse_reset();
    push(5, 0); push(5, 0);
    do_run(0);

    // Reset while a result is pending
    send(99, 1);
    chk("done_valid", 32'(out_valid), 32'd1);
    pulse_reset();

    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        push($urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      do_run($urandom_range(0, 3));
    end
    for (int r = 0; r < 2; r++) begin
      len = $urandom_range(250, 300);
      for (int i = 0; i < len; i++) push($urandom_range(180, 255), 0);
      do_run($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
